// File: rtl/rs232_command_parser.sv
// rs232_command_parser
// Decodes framed commands from a received byte stream and queues a 4-byte ACK/NAK
// response for transmission.
//   Frame:    SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK (CHK = XOR of CMD, LEN, payload)
//   Response: SYNC_BYTE, CMD, STATUS, CMD^STATUS (00 ok, 01 bad checksum, 02 bad length)
// Ports:
//   clock, reset        - clock, asynchronous active-low reset
//   rx_byte, rx_valid   - received byte and its one-cycle qualifier
//   cmd_valid           - one-cycle pulse per good frame
//   cmd_code/len/payload- fields of the last good frame (payload first byte in [63:56])
//   tx_bytes            - response, first byte in the top byte, unused bytes FF
//   tx_num_bytes        - response length (always 4)
//   tx_valid            - one-cycle transmit request, at least TX_GAP cycles apart
//   err_count           - saturating count of checksum/length/timeout/dropped-response errors
module rs232_command_parser #(
  parameter int unsigned MAX_BYTES  = 11,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned RX_TIMEOUT = 50000,
  parameter int unsigned TX_GAP     = 160
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  output logic                   cmd_valid,
  output logic [7:0]             cmd_code,
  output logic [3:0]             cmd_len,
  output logic [63:0]            cmd_payload,
  output logic [MAX_BYTES*8-1:0] tx_bytes,
  output logic [3:0]             tx_num_bytes,
  output logic                   tx_valid,
  output logic [7:0]             err_count
);

  localparam int unsigned TxW  = MAX_BYTES * 8;
  localparam int unsigned TmrW = $clog2(RX_TIMEOUT + 2);
  localparam int unsigned GapW = $clog2(TX_GAP + 2);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(RX_TIMEOUT - 1);
  localparam logic [GapW-1:0] GapLoad = GapW'(TX_GAP);

  typedef enum logic [2:0] {StHunt, StCmd, StLen, StData, StChk, StResp} state_e;

  state_e           state_q;
  logic [7:0]       cmd_q, chk_q;
  logic [3:0]       len_q, cnt_q;
  logic [63:0]      pay_q;
  logic [TmrW-1:0]  timer_q;
  logic [GapW-1:0]  gap_q;
  logic [7:0]       resp_code_q, resp_status_q;
  logic             slot_full_q;
  logic [7:0]       slot_code_q, slot_status_q;
  logic             cmd_valid_q, tx_valid_q;
  logic [7:0]       cmd_code_q, err_q;
  logic [3:0]       cmd_len_q;
  logic [63:0]      cmd_payload_q;
  logic [TxW-1:0]   tx_bytes_q;

  logic             in_frame, timeout, gap_free;
  logic             emit, slot_load, slot_clear, drop;
  logic [7:0]       emit_code, emit_status;
  logic             len_err, chk_err, err_inc;
  logic [5:0]       data_shift;

  function automatic logic [TxW-1:0] resp_frame(input logic [7:0] code,
                                                 input logic [7:0] status);
    logic [TxW-1:0] f;
    f = '1;
    f[TxW-1 -: 32] = {SYNC_BYTE, code, status, code ^ status};
    return f;
  endfunction

  always_comb begin
    in_frame = (state_q == StCmd) || (state_q == StLen) || (state_q == StData) ||
               (state_q == StChk);
    // The RX_TIMEOUT-th consecutive idle cycle aborts; a byte on that cycle wins.
    timeout  = in_frame && !rx_valid && (timer_q == TmrLast);
    // The counter reaches zero on the edge that issues the next pulse, so pulses land
    // exactly TX_GAP cycles apart.
    gap_free = (gap_q <= GapW'(1));

    emit        = 1'b0;
    emit_code   = slot_code_q;
    emit_status = slot_status_q;
    slot_load   = 1'b0;
    slot_clear  = 1'b0;
    drop        = 1'b0;
    if (state_q == StResp) begin
      // Commit the response decided on the previous edge; the older pending one goes first.
      if (slot_full_q) begin
        if (gap_free) begin
          emit      = 1'b1;
          slot_load = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else if (gap_free) begin
        emit        = 1'b1;
        emit_code   = resp_code_q;
        emit_status = resp_status_q;
      end else begin
        slot_load = 1'b1;
      end
    end else if (slot_full_q && gap_free) begin
      emit       = 1'b1;
      slot_clear = 1'b1;
    end

    len_err    = (state_q == StLen) && rx_valid && (rx_byte > 8'd8);
    chk_err    = (state_q == StChk) && rx_valid && (rx_byte != chk_q);
    err_inc    = timeout || len_err || chk_err || drop;
    data_shift = {3'd7 - cnt_q[2:0], 3'b000};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StHunt;
      cmd_q         <= 8'h00;
      chk_q         <= 8'h00;
      len_q         <= 4'd0;
      cnt_q         <= 4'd0;
      pay_q         <= 64'd0;
      timer_q       <= '0;
      gap_q         <= '0;
      resp_code_q   <= 8'h00;
      resp_status_q <= 8'h00;
      slot_full_q   <= 1'b0;
      slot_code_q   <= 8'h00;
      slot_status_q <= 8'h00;
      cmd_valid_q   <= 1'b0;
      tx_valid_q    <= 1'b0;
      cmd_code_q    <= 8'h00;
      cmd_len_q     <= 4'd0;
      cmd_payload_q <= 64'd0;
      tx_bytes_q    <= '1;
      err_q         <= 8'h00;
    end else begin
      cmd_valid_q <= 1'b0;
      tx_valid_q  <= emit;

      if (emit) begin
        tx_bytes_q <= resp_frame(emit_code, emit_status);
        gap_q      <= GapLoad;
      end else if (gap_q != '0) begin
        gap_q <= gap_q - 1'b1;
      end

      if (slot_load) begin
        slot_full_q   <= 1'b1;
        slot_code_q   <= resp_code_q;
        slot_status_q <= resp_status_q;
      end else if (slot_clear) begin
        slot_full_q <= 1'b0;
      end

      if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;

      if (!in_frame || rx_valid) timer_q <= '0;
      else                       timer_q <= timer_q + 1'b1;

      unique case (state_q)
        // StResp also hunts, so a SYNC_BYTE right behind a frame is not lost.
        StHunt, StResp: begin
          state_q <= (rx_valid && (rx_byte == SYNC_BYTE)) ? StCmd : StHunt;
        end
        StCmd: begin
          if (rx_valid) begin
            cmd_q   <= rx_byte;
            chk_q   <= rx_byte;
            pay_q   <= 64'd0;
            state_q <= StLen;
          end
        end
        StLen: begin
          if (rx_valid) begin
            len_q <= rx_byte[3:0];
            chk_q <= chk_q ^ rx_byte;
            cnt_q <= 4'd0;
            if (len_err) begin
              resp_code_q   <= cmd_q;
              resp_status_q <= 8'h02;
              state_q       <= StResp;
            end else if (rx_byte == 8'd0) begin
              state_q <= StChk;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (rx_valid) begin
            pay_q <= pay_q | ({56'd0, rx_byte} << data_shift);
            chk_q <= chk_q ^ rx_byte;
            cnt_q <= cnt_q + 4'd1;
            if ((cnt_q + 4'd1) == len_q) state_q <= StChk;
          end
        end
        StChk: begin
          if (rx_valid) begin
            resp_code_q <= cmd_q;
            state_q     <= StResp;
            if (chk_err) begin
              resp_status_q <= 8'h01;
            end else begin
              resp_status_q <= 8'h00;
              cmd_valid_q   <= 1'b1;
              cmd_code_q    <= cmd_q;
              cmd_len_q     <= len_q;
              cmd_payload_q <= pay_q;
            end
          end
        end
        default: state_q <= StHunt;
      endcase

      if (timeout) state_q <= StHunt;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_code     = cmd_code_q;
  assign cmd_len      = cmd_len_q;
  assign cmd_payload  = cmd_payload_q;
  assign tx_bytes     = tx_bytes_q;
  assign tx_num_bytes = 4'd4;
  assign tx_valid     = tx_valid_q;
  assign err_count    = err_q;

endmodule
